uart_tx_sequencer: RTL and testbench

Frame-level controller that sequences the UART baud clock generator for transmission. It owns the divisor configuration and the generator's enable. It accepts bytes over a valid/ready handshake and serialises start, data, optional parity and stop bits on txd_out, advancing one bit per full bclk period. It sits between the register/FIFO front end and the line pin, and drives the baud clock generator's enable_in and divisor inputs.

---
 rtl/uart_tx_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_uart_tx_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sequencer.sv
// UART transmit frame sequencer: owns the baud generator enable/divisor and shifts
// start/data/[parity]/stop bits out on txd_out. Define UART_TX_PARITY_EN for parity.
module uart_tx_sequencer #(
  parameter int DIV_WIDTH     = 16,
  parameter int RESET_DIVISOR = 16
) (
  input  logic                 clk_in,
  input  logic                 rstn_in,
  input  logic                 bclk_in,
  output logic                 gen_enable_out,
  output logic [DIV_WIDTH-1:0] gen_divisor_out,
  input  logic                 cfg_div_wr_in,
  input  logic [DIV_WIDTH-1:0] cfg_div_in,
  input  logic [1:0]           cfg_wlen_in,
  input  logic                 cfg_stop2_in,
`ifdef UART_TX_PARITY_EN
  input  logic                 cfg_par_en_in,
  input  logic                 cfg_par_odd_in,
`endif
  output logic                 cfg_err_out,
  input  logic                 tx_valid_in,
  input  logic [7:0]           tx_data_in,
  output logic                 tx_ready_out,
  output logic                 tx_busy_out,
  output logic                 tx_done_out,
  output logic                 txd_out
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic                 txd_q, txd_d;
  logic                 en_q, en_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 pend_q, pend_d;
  logic [DIV_WIDTH-1:0] pendVal_q, pendVal_d;
  logic [7:0]           data_q, data_d;
  logic [1:0]           wlen_q, wlen_d;
  logic                 stop2_q, stop2_d;
  logic [2:0]           idx_q, idx_d;
  logic                 stopCnt_q, stopCnt_d;
  logic                 phase_q, phase_d;
  logic                 bclkDly_q;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
`ifdef UART_TX_PARITY_EN
  logic                 parEn_q, parEn_d;
  logic                 parBit_q, parBit_d;
`endif

  logic       accept;
  logic       countedEdge;
  logic       boundary;
  logic       divWrOk;
  logic [7:0] dataMask;

  // A bit boundary is every second counted bclk edge, so bclk polarity is irrelevant.
  assign accept      = tx_valid_in && ready_q;
  assign countedEdge = (bclk_in != bclkDly_q) && en_q;
  assign boundary    = countedEdge && phase_q;
  assign divWrOk     = cfg_div_wr_in && (cfg_div_in >= DIV_WIDTH'(2));
  assign dataMask    = 8'hFF >> (2'd3 - cfg_wlen_in);

  always_comb begin
    state_d   = state_q;
    txd_d     = txd_q;
    en_d      = en_q;
    div_d     = div_q;
    pend_d    = pend_q;
    pendVal_d = pendVal_q;
    data_d    = data_q;
    wlen_d    = wlen_q;
    stop2_d   = stop2_q;
    idx_d     = idx_q;
    stopCnt_d = stopCnt_q;
    phase_d   = countedEdge ? ~phase_q : phase_q;
    done_d    = 1'b0;
    err_d     = cfg_div_wr_in && !divWrOk;
`ifdef UART_TX_PARITY_EN
    parEn_d   = parEn_q;
    parBit_d  = parBit_q;
`endif

    // The divisor may only move while the generator is stopped; otherwise park it.
    if (divWrOk) begin
      if (state_q == IDLE && !accept) begin
        div_d  = cfg_div_in;
        pend_d = 1'b0;
      end else begin
        pend_d    = 1'b1;
        pendVal_d = cfg_div_in;
      end
    end else if (state_q == IDLE && pend_q) begin
      div_d  = pendVal_q;
      pend_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = START;
          txd_d   = 1'b0;
          en_d    = 1'b1;
          phase_d = 1'b0;
          data_d  = tx_data_in & dataMask;
          wlen_d  = cfg_wlen_in;
          stop2_d = cfg_stop2_in;
`ifdef UART_TX_PARITY_EN
          parEn_d  = cfg_par_en_in;
          parBit_d = (^(tx_data_in & dataMask)) ^ cfg_par_odd_in;
`endif
        end
      end
      START: begin
        if (boundary) begin
          state_d = DATA;
          txd_d   = data_q[0];
          idx_d   = 3'd0;
        end
      end
      DATA: begin
        if (boundary) begin
          if (idx_q == {1'b1, wlen_q}) begin
`ifdef UART_TX_PARITY_EN
            if (parEn_q) begin
              state_d = PARITY;
              txd_d   = parBit_q;
            end else begin
              state_d   = STOP;
              txd_d     = 1'b1;
              stopCnt_d = 1'b0;
            end
`else
            state_d   = STOP;
            txd_d     = 1'b1;
            stopCnt_d = 1'b0;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
            txd_d = data_q[idx_q + 3'd1];
          end
        end
      end
      PARITY: begin
        if (boundary) begin
          state_d   = STOP;
          txd_d     = 1'b1;
          stopCnt_d = 1'b0;
        end
      end
      STOP: begin
        if (boundary) begin
          if (stop2_q && !stopCnt_q) begin
            stopCnt_d = 1'b1;
          end else begin
            state_d = IDLE;
            en_d    = 1'b0;
            done_d  = 1'b1;
            txd_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE) && !pend_d;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk_in) begin
    if (!rstn_in) begin
      state_q   <= IDLE;
      txd_q     <= 1'b1;
      en_q      <= 1'b0;
      div_q     <= DIV_WIDTH'(RESET_DIVISOR);
      pend_q    <= 1'b0;
      pendVal_q <= '0;
      data_q    <= 8'd0;
      wlen_q    <= 2'd0;
      stop2_q   <= 1'b0;
      idx_q     <= 3'd0;
      stopCnt_q <= 1'b0;
      phase_q   <= 1'b0;
      bclkDly_q <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parEn_q   <= 1'b0;
      parBit_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      txd_q     <= txd_d;
      en_q      <= en_d;
      div_q     <= div_d;
      pend_q    <= pend_d;
      pendVal_q <= pendVal_d;
      data_q    <= data_d;
      wlen_q    <= wlen_d;
      stop2_q   <= stop2_d;
      idx_q     <= idx_d;
      stopCnt_q <= stopCnt_d;
      phase_q   <= phase_d;
      bclkDly_q <= bclk_in;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef UART_TX_PARITY_EN
      parEn_q   <= parEn_d;
      parBit_q  <= parBit_d;
`endif
    end
  end

  assign gen_enable_out  = en_q;
  assign gen_divisor_out = div_q;
  assign cfg_err_out     = err_q;
  assign tx_ready_out    = ready_q;
  assign tx_busy_out     = busy_q;
  assign tx_done_out     = done_q;
  assign txd_out         = txd_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Self-checking bench for uart_tx_sequencer: a frame-level model (queue of line bits)
// is stepped every clock and compared with all DUT outputs at the falling edge.
module tb_uart_tx_sequencer;

  logic        clk_in = 1'b0;
  logic        rstn_in;
  logic        bclk_in;
  logic        gen_enable_out;
  logic [15:0] gen_divisor_out;
  logic        cfg_div_wr_in;
  logic [15:0] cfg_div_in;
  logic [1:0]  cfg_wlen_in;
  logic        cfg_stop2_in;
  logic        cfg_par_en_in;
  logic        cfg_par_odd_in;
  logic        cfg_err_out;
  logic        tx_valid_in;
  logic [7:0]  tx_data_in;
  logic        tx_ready_out;
  logic        tx_busy_out;
  logic        tx_done_out;
  logic        txd_out;

  int compareCount  = 0;
  int mismatchCount = 0;
  int doneSeen      = 0;
  int bclkHalf      = 3;
  int bclkCnt       = 0;

  // Reference model state: what each output should read after the latest clock edge.
  bit          mBits[$];
  logic        mTxd, mEn, mBusy, mReady, mDone, mErr, mPend, mPhase, mBclkPrev;
  logic [15:0] mDiv, mPendVal;
  int          mAcceptCount = 0;
  int          mDoneCount   = 0;

  uart_tx_sequencer #(.DIV_WIDTH(16), .RESET_DIVISOR(16)) dut (
    .clk_in          (clk_in),
    .rstn_in         (rstn_in),
    .bclk_in         (bclk_in),
    .gen_enable_out  (gen_enable_out),
    .gen_divisor_out (gen_divisor_out),
    .cfg_div_wr_in   (cfg_div_wr_in),
    .cfg_div_in      (cfg_div_in),
    .cfg_wlen_in     (cfg_wlen_in),
    .cfg_stop2_in    (cfg_stop2_in),
`ifdef UART_TX_PARITY_EN
    .cfg_par_en_in   (cfg_par_en_in),
    .cfg_par_odd_in  (cfg_par_odd_in),
`endif
    .cfg_err_out     (cfg_err_out),
    .tx_valid_in     (tx_valid_in),
    .tx_data_in      (tx_data_in),
    .tx_ready_out    (tx_ready_out),
    .tx_busy_out     (tx_busy_out),
    .tx_done_out     (tx_done_out),
    .txd_out         (txd_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mBits.delete();
    mTxd      = 1'b1;
    mEn       = 1'b0;
    mBusy     = 1'b0;
    mReady    = 1'b1;
    mDone     = 1'b0;
    mErr      = 1'b0;
    mPend     = 1'b0;
    mPendVal  = 16'd0;
    mPhase    = 1'b0;
    mBclkPrev = 1'b1;
    mDiv      = 16'd16;
  endtask

  // Advance the model across the upcoming rising edge using the inputs now driven.
  task automatic modelStep();
    logic accept, counted, boundary, wrOk;
    int   nbits;
    bit   par;
    if (!rstn_in) begin
      modelReset();
    end else begin
      accept   = tx_valid_in && mReady;
      counted  = (bclk_in != mBclkPrev) && mEn;
      boundary = counted && mPhase;
      if (counted) mPhase = ~mPhase;
      mDone = 1'b0;
      mErr  = cfg_div_wr_in && (cfg_div_in < 16'd2);
      wrOk  = cfg_div_wr_in && (cfg_div_in >= 16'd2);
      if (wrOk) begin
        if (!mBusy && !accept) begin
          mDiv  = cfg_div_in;
          mPend = 1'b0;
        end else begin
          mPend    = 1'b1;
          mPendVal = cfg_div_in;
        end
      end else if (!mBusy && mPend) begin
        mDiv  = mPendVal;
        mPend = 1'b0;
      end
      if (!mBusy && accept) begin
        nbits = int'(cfg_wlen_in) + 5;
        mBits.delete();
        mBits.push_back(1'b0);
        par = 1'b0;
        for (int i = 0; i < nbits; i++) begin
          mBits.push_back(tx_data_in[i]);
          par = par ^ tx_data_in[i];
        end
`ifdef UART_TX_PARITY_EN
        if (cfg_par_en_in) mBits.push_back(par ^ cfg_par_odd_in);
`endif
        mBits.push_back(1'b1);
        if (cfg_stop2_in) mBits.push_back(1'b1);
        mTxd   = 1'b0;
        mBusy  = 1'b1;
        mEn    = 1'b1;
        mPhase = 1'b0;
        mAcceptCount++;
      end else if (mBusy && boundary) begin
        void'(mBits.pop_front());
        if (mBits.size() == 0) begin
          mBusy = 1'b0;
          mEn   = 1'b0;
          mDone = 1'b1;
          mTxd  = 1'b1;
          mDoneCount++;
        end else begin
          mTxd = mBits[0];
        end
      end
      mReady    = !mBusy && !mPend;
      mBclkPrev = bclk_in;
    end
  endtask

  // One clock: advance the free-running bit clock, step the model, compare every output.
  task automatic applyStimulus();
    bclkCnt++;
    if (bclkCnt >= bclkHalf) begin
      bclkCnt = 0;
      bclk_in = ~bclk_in;
    end
    modelStep();
    @(posedge clk_in);
    @(negedge clk_in);
    cfg_div_wr_in = 1'b0;
    checkOutput("txd",    32'(txd_out),         32'(mTxd));
    checkOutput("enable", 32'(gen_enable_out),  32'(mEn));
    checkOutput("div",    32'(gen_divisor_out), 32'(mDiv));
    checkOutput("ready",  32'(tx_ready_out),    32'(mReady));
    checkOutput("busy",   32'(tx_busy_out),     32'(mBusy));
    checkOutput("done",   32'(tx_done_out),     32'(mDone));
    checkOutput("err",    32'(cfg_err_out),     32'(mErr));
    if (tx_done_out) doneSeen++;
  endtask

  // Send one frame; wrAt >= 0 issues a divisor write that many cycles after accept.
  task automatic sendFrame(input logic [7:0] d, input logic [1:0] wl, input logic s2,
                           input logic pe, input logic po, input bit holdValid,
                           input int wrAt, input logic [15:0] wrVal, output int acceptWait);
    int startAcc;
    int startDone;
    int t;
    startAcc       = mAcceptCount;
    startDone      = mDoneCount;
    tx_valid_in    = 1'b1;
    tx_data_in     = d;
    cfg_wlen_in    = wl;
    cfg_stop2_in   = s2;
    cfg_par_en_in  = pe;
    cfg_par_odd_in = po;
    t = 0;
    while (mAcceptCount == startAcc && t < 200) begin
      applyStimulus();
      t++;
    end
    acceptWait = t;
    if (mAcceptCount == startAcc) checkOutput("acceptTimeout", 32'd0, 32'd1);
    if (!holdValid) tx_valid_in = 1'b0;
    tx_data_in     = 8'($urandom);
    cfg_wlen_in    = 2'($urandom);
    cfg_stop2_in   = 1'($urandom);
    cfg_par_en_in  = 1'($urandom);
    cfg_par_odd_in = 1'($urandom);
    t = 0;
    while (mDoneCount == startDone && t < 2000) begin
      if (t == wrAt) begin
        cfg_div_wr_in = 1'b1;
        cfg_div_in    = wrVal;
      end
      applyStimulus();
      t++;
    end
    if (mDoneCount == startDone) checkOutput("doneTimeout", 32'd0, 32'd1);
  endtask

  initial begin
    int wait0;
    logic [15:0] divBefore;
    rstn_in        = 1'b0;
    bclk_in        = 1'b1;
    cfg_div_wr_in  = 1'b0;
    cfg_div_in     = 16'd0;
    cfg_wlen_in    = 2'd3;
    cfg_stop2_in   = 1'b0;
    cfg_par_en_in  = 1'b0;
    cfg_par_odd_in = 1'b0;
    tx_valid_in    = 1'b0;
    tx_data_in     = 8'd0;
    modelReset();
    @(negedge clk_in);
    applyStimulus();
    applyStimulus();
    rstn_in = 1'b1;
    checkOutput("rstTxd",   32'(txd_out),         32'd1);
    checkOutput("rstEn",    32'(gen_enable_out),  32'd0);
    checkOutput("rstDiv",   32'(gen_divisor_out), 32'd16);
    checkOutput("rstReady", 32'(tx_ready_out),    32'd1);
    checkOutput("rstBusy",  32'(tx_busy_out),     32'd0);
    applyStimulus();

    // Reset mid-frame after moving the divisor away from its reset value.
    cfg_div_wr_in = 1'b1;
    cfg_div_in    = 16'd30;
    applyStimulus();
    checkOutput("idleDivWrite", 32'(gen_divisor_out), 32'd30);
    tx_valid_in  = 1'b1;
    tx_data_in   = 8'hA5;
    cfg_wlen_in  = 2'd3;
    cfg_stop2_in = 1'b0;
    applyStimulus();
    tx_valid_in = 1'b0;
    for (int i = 0; i < 12; i++) applyStimulus();
    rstn_in = 1'b0;
    applyStimulus();
    rstn_in = 1'b1;
    checkOutput("midRstTxd",   32'(txd_out),         32'd1);
    checkOutput("midRstEn",    32'(gen_enable_out),  32'd0);
    checkOutput("midRstReady", 32'(tx_ready_out),    32'd1);
    checkOutput("midRstDiv",   32'(gen_divisor_out), 32'd16);
    applyStimulus();

    // 8N1 0xA5, then 5-bit 0xFF with two stop bits.
    sendFrame(8'hA5, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, -1, 16'd0, wait0);
    checkOutput("a5DoneEnable", 32'(gen_enable_out), 32'd0);
    applyStimulus();
    sendFrame(8'hFF, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, -1, 16'd0, wait0);
    applyStimulus();

    // Divisor written mid-frame is held until the frame ends.
    divBefore = gen_divisor_out;
    sendFrame(8'h3C, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 14, 16'd40, wait0);
    checkOutput("divHeldAtDone",   32'(gen_divisor_out), 32'(divBefore));
    checkOutput("readyLowAtDone",  32'(tx_ready_out),    32'd0);
    applyStimulus();
    checkOutput("divAppliedAfter", 32'(gen_divisor_out), 32'd40);
    checkOutput("readyAfterApply", 32'(tx_ready_out),    32'd1);
    sendFrame(8'h81, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 14, 16'd1, wait0);
    applyStimulus();
    checkOutput("divAfterReject", 32'(gen_divisor_out), 32'd40);

    // Back-to-back frames with valid held high.
    sendFrame(8'h55, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, -1, 16'd0, wait0);
    sendFrame(8'h0F, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, -1, 16'd0, wait0);
    checkOutput("b2bStart", 32'(wait0 <= 2), 32'd1);
    applyStimulus();

`ifdef UART_TX_PARITY_EN
    sendFrame(8'h07, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, -1, 16'd0, wait0);
    applyStimulus();
    sendFrame(8'h07, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, -1, 16'd0, wait0);
    applyStimulus();
`endif

    // Randomised frames, bit-clock rates, divisor writes and idle gaps.
    for (int n = 0; n < 30; n++) begin
      bclkHalf = $urandom_range(1, 4);
      sendFrame(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                bit'($urandom_range(0, 1)),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 30)) : -1,
                16'($urandom_range(0, 60)), wait0);
      if ($urandom_range(0, 3) == 0) begin
        tx_valid_in   = 1'b0;
        cfg_div_wr_in = 1'b1;
        cfg_div_in    = 16'($urandom_range(0, 60));
        applyStimulus();
        applyStimulus();
      end
    end
    tx_valid_in = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput("doneCount", 32'(doneSeen), 32'(mDoneCount));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
